// File: rtl/mux_cfg_ccff.sv
// Routing mux with its own configuration chain. Bits shift serially into a shadow register and
// are validated before they are committed to the active register that drives select and mem buses.
module mux_cfg_ccff #(
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned ENCODED = 0,
    parameter int unsigned OUT_REG = 0
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              ccff_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    input  logic              cfg_commit,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic [NUM_IN-1:0] mem_out,
    output logic [NUM_IN-1:0] mem_inv_out,
    output logic              cfg_ready,
    output logic              cfg_err
);

    localparam int unsigned CfgW = (ENCODED != 0) ? $clog2(NUM_IN) : NUM_IN;
    localparam int unsigned CntW = $clog2(CfgW + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(CfgW);
    localparam logic [CntW-1:0] CntMax  = CntW'(CfgW + 1);

    logic [CfgW-1:0]   shadow_q, shadow_d;
    logic [CfgW-1:0]   active_q, active_d;
    logic              connected_q, connected_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              chain_full, content_valid, commit_ok, commit_conn;
    logic [NUM_IN-1:0] mem_dec;
    logic              out_d;

    assign chain_full = (cnt_q == CntFull);
    assign commit_ok  = cfg_commit & ~ccff_en & chain_full & content_valid;

    if (ENCODED != 0) begin : g_enc
        assign content_valid = (32'(shadow_q) < NUM_IN);
        assign commit_conn   = 1'b1;
        assign mem_dec       = NUM_IN'(1) << active_q;
    end else begin : g_onehot
        // All-zero is the legal "disconnected" setting; only multi-hot content is rejected.
        assign content_valid = ((shadow_q & (shadow_q - CfgW'(1))) == '0);
        assign commit_conn   = |shadow_q;
        assign mem_dec       = active_q;
    end

    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        connected_d = connected_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if (ccff_en) begin
            shadow_d[0] = ccff_head;
            for (int unsigned i = 1; i < CfgW; i++) begin
                shadow_d[i] = shadow_q[i-1];
            end
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        if (commit_ok) begin
            active_d    = shadow_q;
            connected_d = commit_conn;
            cnt_d       = '0;
            err_d       = 1'b0;
        end else if (cfg_commit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            connected_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            connected_q <= connected_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign mem_out     = connected_q ? mem_dec : '0;
    assign mem_inv_out = ~mem_out;
    assign ccff_tail   = shadow_q[CfgW-1];
    assign cfg_ready   = chain_full;
    assign cfg_err     = err_q;
    assign out_d       = |(in & mem_out);

    if (OUT_REG != 0) begin : g_out_reg
        logic out_q;
        always_ff @(posedge prog_clk or negedge pReset_n) begin
            if (!pReset_n) begin
                out_q <= 1'b0;
            end else begin
                out_q <= out_d;
            end
        end
        assign out = out_q;
    end else begin : g_out_comb
        assign out = out_d;
    end

endmodule

// File: tb/tb_mux_cfg_ccff.sv
// Bench for mux_cfg_ccff: one-hot, encoded, chained and registered-output instances checked
// against a bit-level model of the shadow/active/count/error behaviour.
module tb_mux_cfg_ccff;
    localparam int N  = 5;
    localparam int NI = 4;

    logic prog_clk  = 1'b0;
    logic p_reset_n = 1'b0;
    logic         en      [NI];
    logic         head    [NI];
    logic         commit  [NI];
    logic [N-1:0] din     [NI];
    logic         tail    [NI];
    logic         dout    [NI];
    logic [N-1:0] mem     [NI];
    logic [N-1:0] mem_inv [NI];
    logic         rdy     [NI];
    logic         err     [NI];

    int checks = 0;
    int errors = 0;

    // Model: instance 1 is encoded (3 config bits); instance 2 sits behind instance 0 on the chain.
    int unsigned m_w      [NI] = '{5, 3, 5, 5};
    int unsigned m_shadow [NI];
    int unsigned m_cnt    [NI];
    int          m_sel    [NI];
    bit          m_err    [NI];
    bit          m_oreg;

    always #5 prog_clk = ~prog_clk;

    mux_cfg_ccff #(.NUM_IN(N), .ENCODED(0), .OUT_REG(0)) u_oh (
        .prog_clk(prog_clk), .pReset_n(p_reset_n), .ccff_en(en[0]), .ccff_head(head[0]),
        .ccff_tail(tail[0]), .cfg_commit(commit[0]), .in(din[0]), .out(dout[0]),
        .mem_out(mem[0]), .mem_inv_out(mem_inv[0]), .cfg_ready(rdy[0]), .cfg_err(err[0]));
    mux_cfg_ccff #(.NUM_IN(N), .ENCODED(1), .OUT_REG(0)) u_enc (
        .prog_clk(prog_clk), .pReset_n(p_reset_n), .ccff_en(en[1]), .ccff_head(head[1]),
        .ccff_tail(tail[1]), .cfg_commit(commit[1]), .in(din[1]), .out(dout[1]),
        .mem_out(mem[1]), .mem_inv_out(mem_inv[1]), .cfg_ready(rdy[1]), .cfg_err(err[1]));
    mux_cfg_ccff #(.NUM_IN(N), .ENCODED(0), .OUT_REG(0)) u_chain (
        .prog_clk(prog_clk), .pReset_n(p_reset_n), .ccff_en(en[0]), .ccff_head(tail[0]),
        .ccff_tail(tail[2]), .cfg_commit(commit[2]), .in(din[2]), .out(dout[2]),
        .mem_out(mem[2]), .mem_inv_out(mem_inv[2]), .cfg_ready(rdy[2]), .cfg_err(err[2]));
    mux_cfg_ccff #(.NUM_IN(N), .ENCODED(0), .OUT_REG(1)) u_reg (
        .prog_clk(prog_clk), .pReset_n(p_reset_n), .ccff_en(en[3]), .ccff_head(head[3]),
        .ccff_tail(tail[3]), .cfg_commit(commit[3]), .in(din[3]), .out(dout[3]),
        .mem_out(mem[3]), .mem_inv_out(mem_inv[3]), .cfg_ready(rdy[3]), .cfg_err(err[3]));

    function automatic logic [N-1:0] exp_mem(int k);
        if (m_sel[k] < 0) return '0;
        return N'(1) << m_sel[k];
    endfunction

    function automatic int sel_of(int k, int unsigned v);
        if (k == 1) return int'(v);
        if (v == 0) return -1;
        return $clog2(v);
    endfunction

    function automatic bit valid_of(int k, int unsigned v);
        if (k == 1) return v < 5;
        return $countones(v) <= 1;
    endfunction

    function automatic logic m_tail(int k);
        return logic'((m_shadow[k] >> (m_w[k] - 1)) & 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_shadow[k] = 0;
            m_cnt[k]    = 0;
            m_sel[k]    = -1;
            m_err[k]    = 1'b0;
        end
        m_oreg = 1'b0;
    endtask

    // Advance one clock: update the model from the inputs being presented, then cross the edge.
    task automatic step();
        logic t0;
        bit   e;
        logic h;
        t0     = m_tail(0);
        m_oreg = |(din[3] & exp_mem(3));
        for (int k = 0; k < NI; k++) begin
            e = (k == 2) ? en[0] : en[k];
            h = (k == 2) ? t0 : head[k];
            if (commit[k]) begin
                if (!e && m_cnt[k] == m_w[k] && valid_of(k, m_shadow[k])) begin
                    m_sel[k] = sel_of(k, m_shadow[k]);
                    m_cnt[k] = 0;
                    m_err[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
            end
            if (e) begin
                m_shadow[k] = ((m_shadow[k] << 1) | int'(h)) & ((1 << m_w[k]) - 1);
                if (m_cnt[k] < m_w[k] + 1) m_cnt[k]++;
            end
        end
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset();
        p_reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b0; head[k] = 1'b0; commit[k] = 1'b0; din[k] = '0;
        end
        model_reset();
        @(posedge prog_clk);
        #1;
        p_reset_n = 1'b1;
    endtask

    // First bit shifted is value[nbits-1], so a full-width shift leaves shadow equal to value.
    task automatic shift_in(int k, int unsigned value, int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            head[k] = value[i];
            en[k]   = 1'b1;
            step();
        end
        en[k] = 1'b0;
    endtask

    task automatic do_commit(int k);
        commit[k] = 1'b1;
        step();
        commit[k] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NI; k++) begin
            checks++; if (dout[k] !== 1'b0) begin errors++; $display("FAIL reset_out[%0d] got %b want 0", k, dout[k]); end
            checks++; if (mem[k] !== 5'b00000) begin errors++; $display("FAIL reset_mem[%0d] got %b want 00000", k, mem[k]); end
            checks++; if (mem_inv[k] !== 5'b11111) begin errors++; $display("FAIL reset_mem_inv[%0d] got %b want 11111", k, mem_inv[k]); end
            checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d] got %b want 0", k, err[k]); end
            checks++; if (rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b want 0", k, rdy[k]); end
            checks++; if (tail[k] !== 1'b0) begin errors++; $display("FAIL reset_tail[%0d] got %b want 0", k, tail[k]); end
        end
    endtask

    task automatic test_onehot();
        int unsigned r, v;
        do_reset();
        shift_in(0, 'b0010, 4);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL oh_ready_4 got %b want 0", rdy[0]); end
        shift_in(0, 0, 1);
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL oh_ready_5 got %b want 1", rdy[0]); end
        checks++; if (mem[0] !== 5'b00000) begin errors++; $display("FAIL oh_mem_precommit got %b want 00000", mem[0]); end
        do_commit(0);
        checks++; if (mem[0] !== 5'b00100) begin errors++; $display("FAIL oh_mem got %b want 00100", mem[0]); end
        checks++; if (mem_inv[0] !== 5'b11011) begin errors++; $display("FAIL oh_mem_inv got %b want 11011", mem_inv[0]); end
        checks++; if (err[0] !== 1'b0 || rdy[0] !== 1'b0) begin errors++; $display("FAIL oh_flags got err=%b rdy=%b want 0 0", err[0], rdy[0]); end
        for (int i = 0; i < 16; i++) begin
            din[0] = N'($urandom);
            #1;
            checks++; if (dout[0] !== din[0][2]) begin errors++; $display("FAIL oh_follow in=%b got %b want %b", din[0], dout[0], din[0][2]); end
            step();
        end
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 5);
            v = (r == 5) ? 0 : (1 << r);
            shift_in(0, v, 5);
            do_commit(0);
            checks++; if (mem[0] !== exp_mem(0) || mem[0] !== N'(v)) begin errors++; $display("FAIL oh_rand_mem got %b want %b", mem[0], N'(v)); end
            din[0] = N'($urandom);
            #1;
            checks++; if (dout[0] !== |(din[0] & N'(v))) begin errors++; $display("FAIL oh_rand_out in=%b got %b want %b", din[0], dout[0], |(din[0] & N'(v))); end
        end
    endtask

    task automatic test_encoded();
        int unsigned v;
        do_reset();
        shift_in(1, 4, 3);
        checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL enc_ready got %b want 1", rdy[1]); end
        do_commit(1);
        checks++; if (mem[1] !== 5'b10000) begin errors++; $display("FAIL enc_mem4 got %b want 10000", mem[1]); end
        shift_in(1, 6, 3);
        do_commit(1);
        checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL enc_err6 got %b want 1", err[1]); end
        checks++; if (mem[1] !== 5'b10000) begin errors++; $display("FAIL enc_mem_hold got %b want 10000", mem[1]); end
        for (int i = 0; i < 10; i++) begin
            do_reset();
            v = $urandom_range(0, 7);
            shift_in(1, v, 3);
            do_commit(1);
            checks++; if (mem[1] !== exp_mem(1)) begin errors++; $display("FAIL enc_rand_mem v=%0d got %b want %b", v, mem[1], exp_mem(1)); end
            checks++; if (err[1] !== m_err[1]) begin errors++; $display("FAIL enc_rand_err v=%0d got %b want %b", v, err[1], m_err[1]); end
        end
    endtask

    task automatic test_count();
        do_reset();
        shift_in(0, 'b0001, 4);
        do_commit(0);
        checks++; if (err[0] !== 1'b1 || mem[0] !== 5'b00000) begin errors++; $display("FAIL cnt_short got err=%b mem=%b want 1 00000", err[0], mem[0]); end
        do_reset();
        shift_in(0, 'b000001, 6);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL cnt_over_ready got %b want 0", rdy[0]); end
        do_commit(0);
        checks++; if (err[0] !== 1'b1 || mem[0] !== 5'b00000) begin errors++; $display("FAIL cnt_over got err=%b mem=%b want 1 00000", err[0], mem[0]); end
        do_reset();
        shift_in(0, 'b10000, 5);
        commit[0] = 1'b1;
        step();
        checks++; if (mem[0] !== 5'b10000 || err[0] !== 1'b0) begin errors++; $display("FAIL cnt_held_first got mem=%b err=%b want 10000 0", mem[0], err[0]); end
        step();
        commit[0] = 1'b0;
        checks++; if (mem[0] !== 5'b10000 || err[0] !== 1'b1) begin errors++; $display("FAIL cnt_held_second got mem=%b err=%b want 10000 1", mem[0], err[0]); end
        shift_in(0, 'b00001, 5);
        do_commit(0);
        checks++; if (mem[0] !== 5'b00001 || err[0] !== 1'b0) begin errors++; $display("FAIL cnt_exact got mem=%b err=%b want 00001 0", mem[0], err[0]); end
    endtask

    task automatic test_invalid();
        do_reset();
        shift_in(0, 'b01000, 5);
        do_commit(0);
        shift_in(0, 'b00110, 5);
        do_commit(0);
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err[0]); end
        checks++; if (mem[0] !== 5'b01000) begin errors++; $display("FAIL inv_mem got %b want 01000", mem[0]); end
        do_reset();
        shift_in(0, 'b0000, 4);
        head[0] = 1'b1; en[0] = 1'b1; commit[0] = 1'b1;
        step();
        en[0] = 1'b0; commit[0] = 1'b0;
        checks++; if (err[0] !== 1'b1 || mem[0] !== 5'b00000) begin errors++; $display("FAIL coll_reject got err=%b mem=%b want 1 00000", err[0], mem[0]); end
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL coll_shift_ready got %b want 1", rdy[0]); end
        do_commit(0);
        checks++; if (mem[0] !== 5'b00001 || err[0] !== 1'b0) begin errors++; $display("FAIL coll_then_ok got mem=%b err=%b want 00001 0", mem[0], err[0]); end
    endtask

    task automatic test_chain();
        bit q[$];
        bit b;
        do_reset();
        for (int j = 1; j <= 30; j++) begin
            b = 1'($urandom);
            q.push_back(b);
            head[0] = b;
            en[0]   = 1'b1;
            step();
            if (j >= 5) begin
                checks++; if (tail[0] !== q[j-5]) begin errors++; $display("FAIL chain_tail0 j=%0d got %b want %b", j, tail[0], q[j-5]); end
            end
            if (j >= 10) begin
                checks++; if (tail[2] !== q[j-10]) begin errors++; $display("FAIL chain_tail1 j=%0d got %b want %b", j, tail[2], q[j-10]); end
            end
            checks++; if (tail[2] !== m_tail(2)) begin errors++; $display("FAIL chain_model j=%0d got %b want %b", j, tail[2], m_tail(2)); end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_out_reg();
        int unsigned r;
        do_reset();
        r = $urandom_range(0, 4);
        shift_in(3, 1 << r, 5);
        do_commit(3);
        checks++; if (mem[3] !== N'(1 << r)) begin errors++; $display("FAIL oreg_mem got %b want %b", mem[3], N'(1 << r)); end
        for (int i = 0; i < 16; i++) begin
            din[3] = N'($urandom);
            #1;
            checks++; if (dout[3] !== m_oreg) begin errors++; $display("FAIL oreg_hold got %b want %b", dout[3], m_oreg); end
            step();
            checks++; if (dout[3] !== din[3][r]) begin errors++; $display("FAIL oreg_lag got %b want %b", dout[3], din[3][r]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        shift_in(0, 'b00010, 5);
        do_commit(0);
        shift_in(1, 7, 3);
        do_commit(1);
        din[0] = 5'b11111;
        head[0] = 1'b1; en[0] = 1'b1;
        step();
        step();
        #2;
        p_reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++; if (mem[k] !== 5'b00000 || mem_inv[k] !== 5'b11111) begin errors++; $display("FAIL rmid_mem[%0d] got %b/%b want 00000/11111", k, mem[k], mem_inv[k]); end
            checks++; if (dout[k] !== 1'b0 || err[k] !== 1'b0 || rdy[k] !== 1'b0) begin errors++; $display("FAIL rmid_flags[%0d] got out=%b err=%b rdy=%b want 0 0 0", k, dout[k], err[k], rdy[k]); end
        end
        @(posedge prog_clk);
        #1;
        checks++; if (tail[0] !== 1'b0 || tail[2] !== 1'b0) begin errors++; $display("FAIL rmid_tail got %b %b want 0 0", tail[0], tail[2]); end
        do_reset();
        shift_in(0, 'b00001, 5);
        commit[0] = 1'b1;
        #2;
        p_reset_n = 1'b0;
        @(posedge prog_clk);
        #1;
        checks++; if (mem[0] !== 5'b00000 || err[0] !== 1'b0) begin errors++; $display("FAIL rcommit got mem=%b err=%b want 00000 0", mem[0], err[0]); end
        do_reset();
        din[0] = 5'b11111;
        #1;
        checks++; if (dout[0] !== 1'b0 || rdy[0] !== 1'b0) begin errors++; $display("FAIL rcommit_after got out=%b rdy=%b want 0 0", dout[0], rdy[0]); end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b0; head[k] = 1'b0; commit[k] = 1'b0; din[k] = '0;
        end
        model_reset();
        test_reset();
        test_onehot();
        test_encoded();
        test_count();
        test_invalid();
        test_chain();
        test_out_reg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_cfg_ccff.md
# mux_cfg_ccff

Parametrised routing multiplexer with its own configuration-chain memory. It replaces the fixed-size, externally driven one-hot TGATE mux primitives. Configuration bits shift in serially on the chain and are staged in a shadow register. They are checked and committed to an active register, which drives the mux select and the decoded `mem`/`mem_inv` buses. It sits in routing/CB/SB tiles, inline on the tile's configuration chain.

## Interface
- `NUM_IN`, 5, number of mux data inputs; minimum 2.
- `ENCODED`, 0, 0 selects one-hot config (CFG_W = NUM_IN); 1 selects binary config (CFG_W = clog2(NUM_IN)).
- `OUT_REG`, 0, 0 makes `out` combinational; 1 registers `out` on `prog_clk`.

Ports:
- `prog_clk` in 1: single clock for configuration and the optional output register.
- `pReset_n` in 1: reset, asynchronous, active-low.
- `ccff_en` in 1: shift enable for the configuration chain.
- `ccff_head` in 1: chain serial input.
- `ccff_tail` out 1: chain serial output, equal to `shadow[CFG_W-1]`.
- `cfg_commit` in 1: single-cycle request to commit shadow to active.
- `in` in NUM_IN: mux data inputs.
- `out` out 1: mux output.
- `mem_out` out NUM_IN: decoded one-hot select, to drive TGATE S pins.
- `mem_inv_out` out NUM_IN: bitwise inverse of `mem_out`.
- `cfg_ready` out 1: shift count equals CFG_W, so a commit will be accepted if the content is valid.
- `cfg_err` out 1: sticky flag for a rejected commit.

## Operation
- Shift: when `ccff_en`=1, `shadow[0]<=ccff_head` and `shadow[i]<=shadow[i-1]`. The first bit shifted in ends at `shadow[CFG_W-1]`.
- Shift counter: increments on each shift and saturates at CFG_W+1. It is cleared on a successful commit.
- Chain state, derived from the counter:
  - EMPTY when count=0.
  - LOADING when 0<count<CFG_W.
  - FULL when count=CFG_W; `cfg_ready`=1.
  - OVER when count>CFG_W.
- Content validity:
  - One-hot mode: zero or one bit set is valid. All-zero means disconnected.
  - Encoded mode: value < NUM_IN is valid.
- Commit is accepted only when all of the following hold: `cfg_commit`=1, `ccff_en`=0, state FULL, and content valid.
  - On accept: `active<=shadow`, `connected<=` (one-hot: shadow≠0; encoded: 1), count<=0, `cfg_err<=0`.
- Commit is rejected in every other case where `cfg_commit`=1, including when `ccff_en`=1 at the same time.
  - On reject: active and connected are unchanged, `cfg_err<=1`.
  - If `ccff_en`=1, the shift still happens in that cycle.
- Decode: `mem_out` = `active` in one-hot mode, or `1<<active` in encoded mode. It is forced to 0 when `connected`=0.
- Output: `out` = OR over i of (`in[i]` & `mem_out[i]`), so 0 when disconnected.
- `cfg_err` clears only on reset or on an accepted commit.
- The active configuration stays in effect while shifting. Reconfiguration is glitch-free until commit.

## Timing
- Reset (async assert, release synchronous to `prog_clk`) sets:
  - shadow=0, active=0, connected=0, count=0.
  - `ccff_tail`=0, `cfg_ready`=0 (or 1 only if CFG_W=0, which is not permitted), `cfg_err`=0.
  - `mem_out`=0, `mem_inv_out`=all 1s, `out`=0 (also the register when OUT_REG=1).
- `ccff_tail` changes one cycle after each shift edge.
- `cfg_ready` asserts in the cycle after the CFG_W-th shift edge.
- `mem_out`/`mem_inv_out` update on the commit edge and are visible in the next cycle.
- `out` latency:
  - OUT_REG=0: combinational from `in` and `mem_out`, zero cycles.
  - OUT_REG=1: one cycle.
- Reset asserted mid-shift or in the same cycle as a commit: reset wins immediately, all state returns to reset values, and the partial shift is discarded.
- A commit held high for several cycles is evaluated every cycle. After one accept, count=0, so the following cycles reject and set `cfg_err`.

## Test plan
- Reset values: NUM_IN=5, ENCODED=0. Assert `pReset_n`=0 mid-shift → `out`=0, `mem_out`=0, `mem_inv_out`=5'b11111, `cfg_err`=0, `cfg_ready`=0.
- One-hot load: shift 5 bits so shadow=5'b00100, then commit → next cycle `mem_out`=5'b00100. `out` follows `in[2]` while the other inputs toggle.
- Encoded load: NUM_IN=5, ENCODED=1, shift 3'd4 (3 bits), commit → `mem_out`=5'b10000. Shift 3'd6 and commit → `cfg_err`=1, `mem_out` still 5'b10000.
- Count mismatch: shift 4 bits and commit → rejected, `cfg_err`=1. Shift 6 bits and commit → rejected (OVER). Shift exactly 5 and commit a valid value → accepted, `cfg_err`=0.
- Invalid one-hot and collision:
  - shadow=5'b00110, commit → rejected, `cfg_err`=1.
  - `ccff_en` and `cfg_commit` high in the same cycle → shift occurs, commit rejected.
- Chain passthrough and OUT_REG:
  - Two instances chained, 10 bits shifted → each holds its own 5 bits, and `ccff_tail` of the second reproduces the head stream delayed 10 cycles.
  - With OUT_REG=1, `out` lags `in` by exactly 1 cycle.
